// File: rtl/timer_display_ctrl_if.sv
// Avalon-MM bus between timer_display_ctrl (master) and the interval-timer slave port s1.
interface timer_display_ctrl_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [15:0] writedata;
    logic [15:0] readdata;

    modport master (output address, chipselect, write_n, writedata, input readdata);
    modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/timer_display_ctrl.sv
// Programs the interval timer, services its IRQ and keeps an MM:SS BCD elapsed-time count.
// Optional missing-IRQ watchdog: define TIMER_DISPLAY_CTRL_WATCHDOG_EN.
//
// state  | meaning
// IDLE   | bus idle, waiting for enable
// WR_PL  | write period low half
// WR_PH  | write period high half
// WR_CTL | write control START|CONT|ITO
// RUN    | timer running, waiting for IRQ
// ACK    | clear TO in status, advance tick divider
// RD     | read status register
// CHK    | inspect RUN bit of status readback
// STOP   | write control STOP
module timer_display_ctrl #(
    parameter logic [31:0] PERIOD_VALUE  = 32'd49999,
    parameter int          TICKS_PER_SEC = 1000,
    parameter int          WD_SLACK      = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic                        clear,
    timer_display_ctrl_if.master        avm,
    input  logic                        timer_irq,
    output logic                        sec_tick,
    output logic [3:0]                  sec_ones,
    output logic [3:0]                  sec_tens,
    output logic [3:0]                  min_ones,
    output logic [3:0]                  min_tens,
    output logic                        running,
    output logic                        wd_err
);

    typedef enum logic [3:0] {
        IDLE, WR_PL, WR_PH, WR_CTL, RUN, ACK, RD, CHK, STOP
    } state_t;

    localparam int               DIV_W    = $clog2(TICKS_PER_SEC);
    localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(TICKS_PER_SEC - 1);

    state_t           state, state_nxt;
    logic [DIV_W-1:0] div_cnt;
    logic             div_wrap;
    logic             wd_fire;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt      = state;
        avm.chipselect = 1'b0;
        avm.write_n    = 1'b1;
        avm.address    = 3'd0;
        avm.writedata  = 16'h0000;
        case (state)
            IDLE:   if (enable) state_nxt = WR_PL;
            WR_PL: begin
                avm.chipselect = 1'b1;
                avm.write_n    = 1'b0;
                avm.address    = 3'd2;
                avm.writedata  = PERIOD_VALUE[15:0];
                state_nxt      = WR_PH;
            end
            WR_PH: begin
                avm.chipselect = 1'b1;
                avm.write_n    = 1'b0;
                avm.address    = 3'd3;
                avm.writedata  = PERIOD_VALUE[31:16];
                state_nxt      = WR_CTL;
            end
            WR_CTL: begin
                avm.chipselect = 1'b1;
                avm.write_n    = 1'b0;
                avm.address    = 3'd1;
                avm.writedata  = 16'h0007;
                state_nxt      = RUN;
            end
            RUN: begin
                if (!enable)        state_nxt = STOP;
                else if (timer_irq) state_nxt = ACK;
                else if (wd_fire)   state_nxt = WR_PL;
            end
            ACK: begin
                avm.chipselect = 1'b1;
                avm.write_n    = 1'b0;
                state_nxt      = RD;
            end
            RD: begin
                avm.chipselect = 1'b1;
                state_nxt      = CHK;
            end
            // A stopped timer (RUN bit clear) is reprogrammed; the count survives.
            CHK:    state_nxt = avm.readdata[1] ? RUN : WR_PL;
            STOP: begin
                avm.chipselect = 1'b1;
                avm.write_n    = 1'b0;
                avm.address    = 3'd1;
                avm.writedata  = 16'h0008;
                state_nxt      = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    logic unused_rd;
    assign unused_rd = ^{avm.readdata[15:2], avm.readdata[0]};

    assign running  = (state == RUN) || (state == ACK) || (state == RD) || (state == CHK);
    assign div_wrap = (state == ACK) && (div_cnt == '0);
    // clear wins over a wrap in the same cycle, so that second is dropped entirely.
    assign sec_tick = div_wrap && !clear;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            div_cnt  <= DIV_LOAD;
            sec_ones <= 4'd0;
            sec_tens <= 4'd0;
            min_ones <= 4'd0;
            min_tens <= 4'd0;
        end else if (state == ACK) begin
            if (div_cnt != '0) begin
                div_cnt <= div_cnt - 1'b1;
            end else begin
                div_cnt <= DIV_LOAD;
                if (sec_ones != 4'd9) begin
                    sec_ones <= sec_ones + 4'd1;
                end else begin
                    sec_ones <= 4'd0;
                    if (sec_tens != 4'd5) begin
                        sec_tens <= sec_tens + 4'd1;
                    end else begin
                        sec_tens <= 4'd0;
                        if (min_ones != 4'd9) begin
                            min_ones <= min_ones + 4'd1;
                        end else begin
                            min_ones <= 4'd0;
                            min_tens <= (min_tens == 4'd5) ? 4'd0 : min_tens + 4'd1;
                        end
                    end
                end
            end
        end
    end

`ifdef TIMER_DISPLAY_CTRL_WATCHDOG_EN
    // Counts consecutive RUN cycles down from the limit; reaching zero means the IRQ is overdue.
    localparam logic [33:0] WD_LOAD = 34'd2 * (34'(PERIOD_VALUE) + 34'd1) + 34'(WD_SLACK);
    logic [33:0] wd_cnt;

    assign wd_fire = (state == RUN) && enable && !timer_irq && (wd_cnt == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            wd_cnt <= WD_LOAD;
            wd_err <= 1'b0;
        end else begin
            if (state != RUN)      wd_cnt <= WD_LOAD;
            else if (wd_cnt != '0) wd_cnt <= wd_cnt - 34'd1;
            if (wd_fire)           wd_err <= 1'b1;
            else if (clear)        wd_err <= 1'b0;
        end
    end
`else
    localparam int wd_slack_unused = WD_SLACK;
    assign wd_fire = 1'b0;
    assign wd_err  = 1'b0;
`endif

endmodule

// File: tb/tb_timer_display_ctrl.sv
// Scoreboard bench for timer_display_ctrl with a reactive interval-timer slave model.
module tb_timer_display_ctrl;
`ifdef TIMER_DISPLAY_CTRL_WATCHDOG_EN
    localparam logic [31:0] PERIOD = 32'd999;
`else
    localparam logic [31:0] PERIOD = 32'd49999;
`endif
    localparam int TPS     = 4;
    localparam int SLACK   = 16;
    localparam int WD_WAIT = 2 * (int'(PERIOD) + 1) + SLACK + 1;

    logic       clk = 1'b0;
    logic       reset, enable, clear, timer_irq, sec_tick, running, wd_err;
    logic [3:0] sec_ones, sec_tens, min_ones, min_tens;

    timer_display_ctrl_if avm();

    timer_display_ctrl #(
        .PERIOD_VALUE (PERIOD),
        .TICKS_PER_SEC(TPS),
        .WD_SLACK     (SLACK)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .clear    (clear),
        .avm      (avm),
        .timer_irq(timer_irq),
        .sec_tick (sec_tick),
        .sec_ones (sec_ones),
        .sec_tens (sec_tens),
        .min_ones (min_ones),
        .min_tens (min_tens),
        .running  (running),
        .wd_err   (wd_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        is_wr;
        logic [2:0]  addr;
        logic [15:0] data;
    } bus_t;

    bus_t        bus_q[$];
    logic [15:0] tick_q[$];
    bus_t        exp_bus;
    logic [15:0] pend_digits;
    bit          pend = 1'b0;
    int          vectors = 0, errors = 0;
    int          model_ticks = 0, model_secs = 0, ticks_seen = 0;
    int          seen0;
    bit          done;

    logic        to_flag, man_irq = 1'b0, auto_on = 1'b0, force_stop = 1'b0;
    logic [15:0] rd_data;
    int          cd;

    assign avm.readdata = rd_data;
    assign timer_irq    = to_flag | man_irq;

    function automatic logic [15:0] bcd_of(int s);
        int t, m, x;
        t = s % 3600;
        m = t / 60;
        x = t % 60;
        return {4'(m / 10), 4'(m % 10), 4'(x / 10), 4'(x % 10)};
    endfunction

    function automatic void push_bus(logic w, logic [2:0] a, logic [15:0] d);
        bus_t e;
        e.is_wr = w;
        e.addr  = a;
        e.data  = d;
        bus_q.push_back(e);
    endfunction

    function automatic void push_init();
        push_bus(1'b1, 3'd2, PERIOD[15:0]);
        push_bus(1'b1, 3'd3, PERIOD[31:16]);
        push_bus(1'b1, 3'd1, 16'h0007);
    endfunction

    // Reference: one serviced IRQ = ACK write + status read; every TPS IRQs is one second.
    function automatic void model_irq(bit clr);
        push_bus(1'b1, 3'd0, 16'h0000);
        push_bus(1'b0, 3'd0, 16'h0000);
        if (clr) begin
            model_ticks = 0;
            model_secs  = 0;
        end else begin
            model_ticks++;
            if (model_ticks == TPS) begin
                model_ticks = 0;
                model_secs++;
                tick_q.push_back(bcd_of(model_secs));
            end
        end
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Timer slave model: registered readdata, TO cleared by status write, auto IRQ generation.
    always @(posedge clk) begin
        if (reset) begin
            to_flag <= 1'b0;
            rd_data <= 16'h0000;
            cd      <= 0;
        end else begin
            if (avm.chipselect && avm.write_n)
                rd_data <= force_stop ? 16'h0000 : 16'h0002;
            if (avm.chipselect && !avm.write_n && avm.address == 3'd0) begin
                to_flag <= 1'b0;
                cd      <= int'($urandom_range(0, 2));
            end else if (auto_on && !to_flag) begin
                if (cd > 0) begin
                    cd <= cd - 1;
                end else if (model_secs < 3600) begin
                    to_flag <= 1'b1;
                    model_irq(1'b0);
                end
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT shows a bus access or a second tick.
    always @(negedge clk) begin
        if (!reset) begin
            if (pend) begin
                check("digits_after_tick", {min_tens, min_ones, sec_tens, sec_ones}, pend_digits);
                pend = 1'b0;
            end
            if (avm.chipselect) begin
                if (bus_q.size() == 0) begin
                    vectors++;
                    errors++;
                    $display("FAIL bus_unexpected: got access addr=%0d write=%0d data=0x%0h, required none",
                             avm.address, !avm.write_n, avm.writedata);
                end else begin
                    exp_bus = bus_q.pop_front();
                    check("bus_kind", !avm.write_n, exp_bus.is_wr);
                    check("bus_addr", avm.address, exp_bus.addr);
                    if (exp_bus.is_wr) check("bus_wdata", avm.writedata, exp_bus.data);
                end
            end
            if (sec_tick) begin
                ticks_seen++;
                if (tick_q.size() == 0) begin
                    vectors++;
                    errors++;
                    $display("FAIL tick_unexpected: got sec_tick=1, required 0");
                end else begin
                    pend_digits = tick_q.pop_front();
                    pend        = 1'b1;
                end
            end
        end
    end

    // Caller is at a negedge with the FSM in RUN and no IRQ pending.
    task automatic manual_irq(input bit clr_same);
        model_irq(clr_same);
        if (force_stop) push_init();
        man_irq = 1'b1;
        @(posedge clk); #1;
        man_irq = 1'b0;
        clear   = clr_same;
        @(negedge clk);
        check("irq_ack_n1", {avm.chipselect, avm.write_n, avm.address}, {1'b1, 1'b0, 3'd0});
        if (clr_same) check("clear_tick_lost", sec_tick, 1'b0);
        @(posedge clk); #1;
        clear = 1'b0;
        @(negedge clk);
        check("irq_read_n2", {avm.chipselect, avm.write_n, avm.address}, {1'b1, 1'b1, 3'd0});
        check("irq_low_n2", timer_irq, 1'b0);
        if (clr_same) check("clear_digits", {min_tens, min_ones, sec_tens, sec_ones}, 16'h0000);
        @(negedge clk);
        check("irq_chk_n3", avm.chipselect, 1'b0);
        @(negedge clk);
        if (force_stop)
            check("reinit_n4", {avm.chipselect, avm.write_n, avm.address}, {1'b1, 1'b0, 3'd2});
        else
            check("irq_run_n4", {running, avm.chipselect}, 2'b10);
    endtask

    initial begin
        repeat (99000) @(posedge clk);
        $display("FAIL global_timeout: still running after 99000 cycles, required finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        reset  = 1'b1;
        enable = 1'b0;
        clear  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_bus", {avm.chipselect, avm.write_n, avm.address, avm.writedata},
              {1'b0, 1'b1, 3'd0, 16'h0000});
        check("rst_flags", {running, sec_tick, wd_err}, 3'b000);
        check("rst_digits", {min_tens, min_ones, sec_tens, sec_ones}, 16'h0000);
        reset = 1'b0;
        @(negedge clk);

        // Start: three writes on consecutive cycles, RUN on the fourth.
        push_init();
        enable = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            check("start_write", {avm.chipselect, avm.write_n, running}, 3'b100);
        end
        @(negedge clk);
        check("start_run_c4", {running, avm.chipselect}, 2'b10);

        manual_irq(1'b0);

        // Stopped-timer readback: reprogram, count untouched.
        force_stop = 1'b1;
        manual_irq(1'b0);
        force_stop = 1'b0;
        repeat (3) @(negedge clk);
        check("reinit_back_run", running, 1'b1);
        check("reinit_digits", {min_tens, min_ones, sec_tens, sec_ones}, bcd_of(model_secs));

        while (!(model_secs >= 2 && model_ticks == TPS - 1)) manual_irq(1'b0);
        check("pre_clear_digits", {min_tens, min_ones, sec_tens, sec_ones}, bcd_of(model_secs));
        manual_irq(1'b1);

        // Long run from 00:00 through 59:59 and one more second.
        seen0   = ticks_seen;
        done    = 1'b0;
        auto_on = 1'b1;
        for (int i = 0; i < 85000 && !done; i++) begin
            @(negedge clk);
            if (model_secs == 3600 && bus_q.size() == 0 && tick_q.size() == 0 && !pend) done = 1'b1;
        end
        auto_on = 1'b0;
        check("auto_completed", done, 1'b1);
        check("auto_sec_ticks", ticks_seen - seen0, 3600);
        repeat (2) @(negedge clk);
        check("wrap_digits", {min_tens, min_ones, sec_tens, sec_ones}, 16'h0000);
        check("wrap_running", running, 1'b1);

        push_bus(1'b1, 3'd1, 16'h0008);
        enable = 1'b0;
        @(negedge clk);
        check("stop_write", {running, avm.chipselect, avm.write_n, avm.address}, {1'b0, 1'b1, 1'b0, 3'd1});
        @(negedge clk);
        check("idle_bus", {running, avm.chipselect, avm.write_n, avm.address, avm.writedata},
              {1'b0, 1'b0, 1'b1, 3'd0, 16'h0000});

        // enable dropped mid-programming: finish to RUN, then stop.
        push_init();
        push_bus(1'b1, 3'd1, 16'h0008);
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        repeat (3) @(negedge clk);
        check("drop_reaches_run", running, 1'b1);
        repeat (2) @(negedge clk);
        check("drop_ends_idle", {running, avm.chipselect}, 2'b00);

`ifdef TIMER_DISPLAY_CTRL_WATCHDOG_EN
        push_init();
        enable = 1'b1;
        repeat (4) @(negedge clk);
        check("wd_start_run", running, 1'b1);
        push_init();
        repeat (WD_WAIT - 1) @(negedge clk);
        check("wd_not_early", wd_err, 1'b0);
        @(negedge clk);
        check("wd_err_set", wd_err, 1'b1);
        repeat (3) @(negedge clk);
        clear = 1'b1;
        model_ticks = 0;
        model_secs  = 0;
        @(negedge clk);
        clear = 1'b0;
        check("wd_err_cleared", wd_err, 1'b0);
        push_bus(1'b1, 3'd1, 16'h0008);
        enable = 1'b0;
        repeat (3) @(negedge clk);
`else
        check("wd_err_tied", wd_err, 1'b0);
`endif

        for (int i = 0; i < 50 && (bus_q.size() != 0 || tick_q.size() != 0); i++) @(negedge clk);
        check("scoreboard_empty", bus_q.size() + tick_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/timer_display_ctrl.md
# timer_display_ctrl

Avalon-MM master that drives the interval-timer slave in the timer_display subsystem: programs it once, services its periodic IRQ, and turns timeouts into an MM:SS BCD elapsed-time count for the 7-segment display. Sits between the timer slave port (s1) and the display decoder. It replaces the Nios software loop, so the display runs with no CPU.

## Interface
- PERIOD_VALUE, 32'd49999, timer period written to periodl/periodh (1 ms at 50 MHz)
- TICKS_PER_SEC, 1000, timer IRQs per displayed second (≥2)
- WD_SLACK, 16, extra cycles beyond 2*(PERIOD_VALUE+1) before watchdog fires
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  level; 1 = run the clock, 0 = stop the timer
- clear  in  1  single-cycle pulse; zero the MM:SS count
- avm_address  out  3  timer register index (0 status, 1 control, 2 periodl, 3 periodh)
- avm_chipselect  out  1  bus access strobe
- avm_write_n  out  1  active-low write
- avm_writedata  out  16  write data
- avm_readdata  in  16  timer read data, registered by the slave
- timer_irq  in  1  timer interrupt, level
- sec_tick  out  1  one-cycle pulse per displayed second
- sec_ones, sec_tens, min_ones, min_tens  out  4 each  BCD digits
- running  out  1  1 while FSM is in RUN/ACK/RD/CHK
- wd_err  out  1  sticky watchdog error (only with macro)

## Operation
- FSM states: IDLE, WR_PL, WR_PH, WR_CTL, RUN, ACK, RD, CHK, STOP.
- IDLE: bus idle (chipselect 0, write_n 1, address 0, writedata 0). enable=1 -> WR_PL.
- WR_PL: write address 2, data PERIOD_VALUE[15:0]. WR_PH: write address 3, data PERIOD_VALUE[31:16]. WR_CTL: write address 1, data 16'h0007 (START|CONT|ITO). -> RUN.
- RUN: bus idle. enable=0 -> STOP. Else timer_irq=1 -> ACK.
- ACK: write address 0, data 0 (clears TO). Increment tick divider. -> RD.
- RD: read cycle, address 0, chipselect 1, write_n 1. -> CHK.
- CHK: sample avm_readdata. Bit1 (RUN)=0 -> WR_PL (re-init, count kept). Else -> RUN.
- STOP: write address 1, data 16'h0008 (STOP). -> IDLE.
- Tick divider counts 0..TICKS_PER_SEC-1. Wrap pulses sec_tick and advances BCD.
- BCD chain: sec_ones 9→0 carries to sec_tens; sec_tens 5→0 carries to min_ones; min_ones 9→0 carries to min_tens; min_tens 5→0. 59:59 → 00:00.
- clear: zeroes digits and divider. It beats a same-cycle tick, and that tick is lost. FSM state is unaffected.
- enable dropping during WR_PL/WR_PH/WR_CTL: sequence completes to RUN, then RUN → STOP.

## Timing
- Reset: FSM IDLE; all outputs 0 except avm_write_n=1.
- Every bus access takes exactly one cycle; the slave has no waitrequest.
- Start latency: enable=1 sampled in IDLE; writes on the next 3 cycles; RUN on the 4th.
- IRQ service: timer_irq seen in RUN at cycle n; ACK write at n+1; RD at n+2; CHK at n+3; RUN at n+4. timer_irq is low by n+2, so there is no double count.
- Read latency 1: address presented in RD, data valid in CHK.
- sec_tick is asserted in the ACK cycle that wraps the divider. Digits update on the following edge.
- With the minimum period, a new IRQ arriving during RD/CHK is held (level) and serviced on return to RUN.

## Configuration
- TIMER_DISPLAY_CTRL_WATCHDOG_EN defined:
  - A cycle counter runs in RUN and restarts in ACK.
  - If it exceeds 2*(PERIOD_VALUE+1)+WD_SLACK, wd_err sets (sticky until reset or clear) and the FSM goes to WR_PL.
- Undefined: no counter, wd_err tied 0.

## Test plan
- Reset, then enable=1: bus shows writes (2,0xC34F), (3,0x0000), (1,0x0007) on consecutive cycles. running=1 on the 4th cycle.
- Timer model IRQ: ACK write (0,0x0000) one cycle later, then read of address 0. Model returns 0x0002; FSM is back in RUN at n+4.
- TICKS_PER_SEC=4, 3599 seconds of IRQs, starting from 00:00: digits reach 59:59; one more second gives 00:00 with one sec_tick.
- CHK readback 0x0000 (RUN bit clear) → WR_PL sequence reissued; digits unchanged.
- enable=0 in RUN → single write (1,0x0008), then IDLE, running=0. clear coincident with a wrap tick → digits 00:00, divider 0.
- Watchdog (macro on): withhold IRQ for 2*(PERIOD_VALUE+1)+WD_SLACK+1 cycles → wd_err=1 and re-init writes follow. clear → wd_err=0.
